// File: rtl/spad_arbiter.sv
// Scratchpad access arbiter: N requesters share one scratchpad port, one transaction in flight.
// Define SPAD_ARB_RR_EN for round-robin arbitration; otherwise lowest index wins.
module spad_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      sc_read_en,
  output logic                      sc_write_en,
  output logic [ADDR_W-1:0]         sc_addr,
  output logic [DATA_W-1:0]         sc_data_in,
  input  logic [DATA_W-1:0]         sc_data_out,
  input  logic                      sc_ready,
  output logic                      busy
);

  localparam int IDX_W = (NUM_REQ > 2) ? 2 : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic                 w_grant;
  logic                 w_any;
  logic [IDX_W-1:0]     w_win;
  logic [ADDR_W-1:0]    w_addr  [NUM_REQ];
  logic [DATA_W-1:0]    w_wdata [NUM_REQ];

  logic [IDX_W-1:0]     r_win;
  logic                 r_write;
  logic [ADDR_W-1:0]    r_addr;
  logic [DATA_W-1:0]    r_wdata;
  logic [DATA_W-1:0]    r_rdata;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_addr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
      assign w_wdata[gi] = req_wdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  assign w_any = |req_valid;

`ifdef SPAD_ARB_RR_EN
  logic [IDX_W-1:0] r_ptr;
  logic             w_found;

  // Search starts one past the last winner and wraps around.
  always_comb begin
    int c;
    c       = 0;
    w_win   = '0;
    w_found = 1'b0;
    for (int o = 1; o <= NUM_REQ; o++) begin
      c = int'(r_ptr) + o;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      if (!w_found && req_valid[IDX_W'(c)]) begin
        w_found = 1'b1;
        w_win   = IDX_W'(c);
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_ptr <= IDX_W'(NUM_REQ - 1);
    end else if (w_grant) begin
      r_ptr <= w_win;
    end
  end
`else
  always_comb begin
    w_win = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) w_win = IDX_W'(i);
    end
  end
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    req_ready    = '0;
    rsp_valid    = '0;
    rsp_rdata    = '0;
    sc_read_en   = 1'b0;
    sc_write_en  = 1'b0;
    sc_addr      = '0;
    sc_data_in   = '0;
    busy         = 1'b0;
    case (r_state)
      IDLE: begin
        // Grant is suppressed while reset is held so req_ready reads zero immediately.
        if (w_any && n_rst) begin
          w_grant      = 1'b1;
          req_ready    = NUM_REQ'(1) << w_win;
          w_state_next = BUSY;
        end
      end
      BUSY: begin
        busy        = 1'b1;
        sc_addr     = r_addr;
        sc_data_in  = r_wdata;
        sc_read_en  = ~r_write;
        sc_write_en = r_write;
        if (sc_ready) w_state_next = RESP;
      end
      RESP: begin
        busy         = 1'b1;
        rsp_valid    = NUM_REQ'(1) << r_win;
        rsp_rdata    = r_rdata;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_win   <= '0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if (w_grant) begin
        r_win   <= w_win;
        r_write <= req_write[w_win];
        r_addr  <= w_addr[w_win];
        r_wdata <= w_wdata[w_win];
      end
      // Writes keep the previous capture so rsp_rdata is stale but defined.
      if (r_state == BUSY && sc_ready && !r_write) begin
        r_rdata <= sc_data_out;
      end
    end
  end

endmodule

// File: doc/spad_arbiter.md
SPAD_ARBITER -- requirements
Module: spad_arbiter

Interface
REQ-001 The block SHALL take parameter NUM_REQ, default 3, number of requesters (legal 2..4; index 0 = host controller, 1 = array operand fetch, 2 = array result writeback).
REQ-002 The block SHALL take parameter ADDR_W, default 32, scratchpad address width.
REQ-003 The block SHALL take parameter DATA_W, default 32, scratchpad data width.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 n_rst  input  1  reset, asynchronous, active-low.
REQ-006 req_valid  input  NUM_REQ  per-requester access request.
REQ-007 req_write  input  NUM_REQ  per-requester direction, 1 = write, 0 = read.
REQ-008 req_addr  input  NUM_REQ*ADDR_W  packed per-requester address, requester i at bits [i*ADDR_W +: ADDR_W].
REQ-009 req_wdata  input  NUM_REQ*DATA_W  packed per-requester write data, same packing.
REQ-010 req_ready  output  NUM_REQ  one-hot grant/accept strobe.
REQ-011 rsp_valid  output  NUM_REQ  one-hot completion strobe.
REQ-012 rsp_rdata  output  DATA_W  read data, shared, valid only with rsp_valid.
REQ-013 sc_read_en, sc_write_en  output  1 each  scratchpad strobes, never both high.
REQ-014 sc_addr  output  ADDR_W; sc_data_in  output  DATA_W; sc_data_out  input  DATA_W; sc_ready  input  1  scratchpad completion.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, BUSY, RESP; one transaction outstanding at a time.
REQ-017 IDLE: if any req_valid high, SHALL select winner w, assert req_ready[w] combinationally that cycle, latch addr/wdata/write/w, go to BUSY; else stay IDLE with req_ready all zero.
REQ-018 BUSY: SHALL drive sc_addr, sc_data_in from latched values and hold sc_read_en or sc_write_en per latched direction every cycle until sc_ready sampled high.
REQ-019 BUSY with sc_ready high: SHALL capture sc_data_out (reads only; writes leave the capture register unchanged) and go to RESP.
REQ-020 RESP: SHALL assert rsp_valid[w] for exactly one cycle with rsp_rdata = captured data, then return to IDLE; no grant issued in RESP.
REQ-021 Latency: grant at cycle T, scratchpad strobe from T+1, sc_ready at T+k (k>=1), rsp_valid at T+k+1; next grant earliest T+k+2.
REQ-022 Changes on req_* after grant SHALL NOT affect the in-flight transaction.
REQ-023 sc_ready while in IDLE or RESP SHALL be ignored.
REQ-024 Outside BUSY, sc_read_en, sc_write_en, sc_addr, sc_data_in SHALL be zero.
REQ-025 A requester re-asserting req_valid during its own RESP cycle SHALL be arbitrated normally in the following IDLE cycle.

Reset
REQ-026 On n_rst low, immediately: state IDLE, req_ready=0, rsp_valid=0, rsp_rdata=0, sc_read_en=0, sc_write_en=0, sc_addr=0, sc_data_in=0, busy=0, round-robin pointer = NUM_REQ-1.
REQ-027 Reset mid-BUSY SHALL abort the transaction with no rsp_valid issued for it.

Configuration
REQ-028 Macro SPAD_ARB_RR_EN defined: round-robin; search starts at pointer+1 modulo NUM_REQ; pointer updated to w on each grant.
REQ-029 Macro SPAD_ARB_RR_EN undefined: fixed priority, lowest asserted index wins; pointer logic absent.

Verification
REQ-030 Single read: req 1 read addr 0x40, sc_ready after 3 BUSY cycles with sc_data_out 0xDEADBEEF -> req_ready[1] at T, sc_read_en T+1..T+3, rsp_valid[1] at T+4 with rsp_rdata 0xDEADBEEF.
REQ-031 Single write: req 2 write addr 0x10 data 0x1234 -> sc_write_en with sc_addr 0x10, sc_data_in 0x1234 until sc_ready, sc_read_en never high, rsp_valid[2] one cycle.
REQ-032 All three valid continuously, RR enabled, sc_ready 1 cycle -> grant order 0,1,2,0,1,2 with grants 3 cycles apart.
REQ-033 Same stimulus, SPAD_ARB_RR_EN undefined -> requester 0 granted every transaction, 1 and 2 never.
REQ-034 Requester changes req_addr 0x40->0x80 after grant -> sc_addr stays 0x40 for whole BUSY phase.
REQ-035 n_rst pulsed low in BUSY -> all outputs zero immediately, no rsp_valid, first grant after reset goes to requester 0.
